reversi_flow_ctrl: RTL and testbench

//  Parametrised top-level game-flow FSM for Reversi on an N x N board. Sequences

---
 rtl/reversi_flow_ctrl.sv | 174 +++++++++++++++++
 tb/tb_reversi_flow_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reversi_flow_ctrl.sv
// Reversi game-flow controller: sequences datapath ops over a start/done handshake
// and owns the cursor, the current player and the invalid-move message timer.
module reversi_flow_ctrl #(
    parameter int BOARD_N    = 8,
    parameter int CW         = 3,
    parameter int MSG_CYCLES = 50_000_000,
    parameter int WRAP       = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          key_enter,
    input  logic          key_right,
    input  logic          key_left,
    input  logic          key_up,
    input  logic          key_down,
    input  logic          op_done,
    input  logic          valid_move,
    input  logic          has_turn,
    output logic          op_start,
    output logic [3:0]    op_code,
    output logic          write_en,
    output logic [CW-1:0] cursor_x,
    output logic [CW-1:0] cursor_y,
    output logic          player,
    output logic          game_over,
    output logic [4:0]    state_o
);

    localparam int            TW   = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;
    localparam logic [CW-1:0] MAXC = CW'(BOARD_N - 1);
    localparam logic [TW-1:0] LAST = TW'(MSG_CYCLES - 1);

    typedef enum logic [4:0] {
        BOOT, DRAW_BOARD, DRAW_INIT, DRAW_CUR, WAIT_INPUT, MOVE_ERASE,
        CHECK, PLACE, FLIP, SCORE, OPP, CUR, SWITCH, INV_SHOW, INV_HOLD,
        INV_ERASE, END_ERASE, WIN, WIN_WAIT, CLEAR
    } state_t;

    typedef enum logic [1:0] {DIR_R, DIR_L, DIR_U, DIR_D} dir_t;

    state_t        state, nxt;
    dir_t          dir, keyDir;
    logic          keyDirValid, blocked, doneSeen;
    logic [TW-1:0] timer;

    function automatic logic [3:0] opOf(input state_t s);
        case (s)
            DRAW_BOARD:           return 4'd1;
            DRAW_INIT:            return 4'd2;
            DRAW_CUR:             return 4'd3;
            MOVE_ERASE,END_ERASE: return 4'd4;
            CHECK:                return 4'd5;
            PLACE:                return 4'd6;
            FLIP:                 return 4'd7;
            SCORE:                return 4'd8;
            OPP:                  return 4'd9;
            CUR:                  return 4'd10;
            INV_SHOW:             return 4'd11;
            INV_ERASE:            return 4'd12;
            WIN:                  return 4'd13;
            CLEAR:                return 4'd14;
            default:              return 4'd0;
        endcase
    endfunction

    // Only pure queries (check, score, turn checks) leave the frame buffer alone.
    function automatic logic weOf(input logic [3:0] c);
        return !(c == 4'd0 || c == 4'd5 || c == 4'd8 || c == 4'd9 || c == 4'd10);
    endfunction

    // op_done in the start cycle belongs to no op we issued yet.
    assign doneSeen = op_done && !op_start;
    assign state_o  = state;

    always_comb begin
        keyDir      = DIR_R;
        keyDirValid = 1'b1;
        if (key_right)      keyDir = DIR_R;
        else if (key_left)  keyDir = DIR_L;
        else if (key_up)    keyDir = DIR_U;
        else if (key_down)  keyDir = DIR_D;
        else                keyDirValid = 1'b0;

        blocked = 1'b0;
        if (WRAP == 0) begin
            case (keyDir)
                DIR_R:   blocked = (cursor_x == MAXC);
                DIR_L:   blocked = (cursor_x == '0);
                DIR_U:   blocked = (cursor_y == '0);
                default: blocked = (cursor_y == MAXC);
            endcase
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            BOOT:       nxt = DRAW_BOARD;
            DRAW_BOARD: if (doneSeen) nxt = DRAW_INIT;
            DRAW_INIT:  if (doneSeen) nxt = DRAW_CUR;
            DRAW_CUR:   if (doneSeen) nxt = WAIT_INPUT;
            WAIT_INPUT: begin
                if (key_enter)                    nxt = CHECK;
                else if (keyDirValid && !blocked) nxt = MOVE_ERASE;
            end
            MOVE_ERASE: if (doneSeen) nxt = DRAW_CUR;
            CHECK:      if (doneSeen) nxt = valid_move ? PLACE : INV_SHOW;
            PLACE:      if (doneSeen) nxt = FLIP;
            FLIP:       if (doneSeen) nxt = SCORE;
            SCORE:      if (doneSeen) nxt = OPP;
            OPP:        if (doneSeen) nxt = has_turn ? SWITCH : CUR;
            SWITCH:     nxt = DRAW_CUR;
            CUR:        if (doneSeen) nxt = has_turn ? DRAW_CUR : END_ERASE;
            INV_SHOW:   if (doneSeen) nxt = INV_HOLD;
            INV_HOLD:   if (timer == LAST) nxt = INV_ERASE;
            INV_ERASE:  if (doneSeen) nxt = WAIT_INPUT;
            END_ERASE:  if (doneSeen) nxt = WIN;
            WIN:        if (doneSeen) nxt = WIN_WAIT;
            WIN_WAIT:   if (key_enter) nxt = CLEAR;
            CLEAR:      if (doneSeen) nxt = DRAW_BOARD;
            default:    nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= BOOT;
            op_start  <= 1'b0;
            op_code   <= 4'd0;
            write_en  <= 1'b0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            player    <= 1'b0;
            game_over <= 1'b0;
            timer     <= '0;
            dir       <= DIR_R;
        end else begin
            state    <= nxt;
            op_start <= (nxt != state) && (opOf(nxt) != 4'd0);
            op_code  <= opOf(nxt);
            write_en <= weOf(opOf(nxt));

            if (state == WAIT_INPUT && nxt == MOVE_ERASE)
                dir <= keyDir;

            // Explicit edge compares so non-power-of-2 boards wrap correctly.
            if (state == MOVE_ERASE && doneSeen) begin
                case (dir)
                    DIR_R:   cursor_x <= (cursor_x == MAXC) ? '0 : cursor_x + CW'(1);
                    DIR_L:   cursor_x <= (cursor_x == '0) ? MAXC : cursor_x - CW'(1);
                    DIR_U:   cursor_y <= (cursor_y == '0) ? MAXC : cursor_y - CW'(1);
                    default: cursor_y <= (cursor_y == MAXC) ? '0 : cursor_y + CW'(1);
                endcase
            end

            if (state == INV_HOLD)
                timer <= (timer == LAST) ? '0 : timer + TW'(1);

            if (state == SWITCH)
                player <= ~player;

            if (state == CUR && nxt == END_ERASE)
                game_over <= 1'b1;

            if (state == CLEAR && doneSeen) begin
                cursor_x  <= '0;
                cursor_y  <= '0;
                player    <= 1'b0;
                game_over <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reversi_flow_ctrl.sv
// Directed bench: one wrapping and one clamping 6x6 controller share the keys;
// each has its own datapath responder answering op_done 3 cycles after op_start.
module tb_reversi_flow_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic kEnter = 0, kRight = 0, kLeft = 0, kUp = 0, kDown = 0;
    logic validMove = 0, hasTurn = 0;

    logic       opDoneW, opStartW, weW, playerW, goW;
    logic [3:0] opCodeW;
    logic [2:0] xW, yW;
    logic [4:0] stW;
    logic       opDoneC, opStartC, weC, playerC, goC;
    logic [3:0] opCodeC;
    logic [2:0] xC, yC;
    logic [4:0] stC;

    int nVec = 0, nFail = 0, weErr = 0, cyc = 0;
    int logW[$], logC[$], stampW[$];
    int cntW = 0, cntC = 0;
    logic prevStartW = 0;

    always #5 clk = ~clk;

    reversi_flow_ctrl #(.BOARD_N(6), .CW(3), .MSG_CYCLES(4), .WRAP(1)) dutW (
        .clk(clk), .resetn(resetn), .key_enter(kEnter), .key_right(kRight),
        .key_left(kLeft), .key_up(kUp), .key_down(kDown), .op_done(opDoneW),
        .valid_move(validMove), .has_turn(hasTurn), .op_start(opStartW),
        .op_code(opCodeW), .write_en(weW), .cursor_x(xW), .cursor_y(yW),
        .player(playerW), .game_over(goW), .state_o(stW));

    reversi_flow_ctrl #(.BOARD_N(6), .CW(3), .MSG_CYCLES(4), .WRAP(0)) dutC (
        .clk(clk), .resetn(resetn), .key_enter(kEnter), .key_right(kRight),
        .key_left(kLeft), .key_up(kUp), .key_down(kDown), .op_done(opDoneC),
        .valid_move(validMove), .has_turn(hasTurn), .op_start(opStartC),
        .op_code(opCodeC), .write_en(weC), .cursor_x(xC), .cursor_y(yC),
        .player(playerC), .game_over(goC), .state_o(stC));

    // Datapath stand-ins: op_done is high exactly 3 cycles after the op_start cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cntW <= 0; opDoneW <= 0; cntC <= 0; opDoneC <= 0;
        end else begin
            opDoneW <= (cntW == 2);
            cntW    <= opStartW ? 1 : ((cntW != 0 && cntW < 3) ? cntW + 1 : 0);
            opDoneC <= (cntC == 2);
            cntC    <= opStartC ? 1 : ((cntC != 0 && cntC < 3) ? cntC + 1 : 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic expWe(input logic [3:0] c);
        return !(c == 0 || c == 5 || c == 8 || c == 9 || c == 10);
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            if (opStartW) begin logW.push_back(int'(opCodeW)); stampW.push_back(cyc); end
            if (opStartC) logC.push_back(int'(opCodeC));
            if (weW !== expWe(opCodeW) || weC !== expWe(opCodeC)) weErr <= weErr + 1;
            if (opStartW && prevStartW) weErr <= weErr + 1;
            prevStartW <= opStartW;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int q[$]);
        logic [63:0] r = 0;
        foreach (q[i]) r = (r << 4) | 64'(q[i] & 15);
        return r;
    endfunction

    task automatic chkOps(input string tag, input int q[$], input int n, input logic [63:0] exp);
        chk({tag, "_len"}, 64'(q.size()), 64'(n));
        chk(tag, pk(q), exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic e, input logic r, input logic l, input logic u, input logic d);
        @(negedge clk);
        kEnter = e; kRight = r; kLeft = l; kUp = u; kDown = d;
        @(negedge clk);
        kEnter = 0; kRight = 0; kLeft = 0; kUp = 0; kDown = 0;
    endtask

    task automatic clearLogs();
        logW.delete(); logC.delete(); stampW.delete();
    endtask

    initial begin
        // reset values
        idle(3);
        chk("rst_op_start", opStartW, 0);
        chk("rst_op_code", opCodeW, 0);
        chk("rst_write_en", weW, 0);
        chk("rst_cursor", {xW, yW}, 0);
        chk("rst_player_go", {playerW, goW}, 0);

        // boot sequence
        resetn = 1;
        idle(30);
        chkOps("boot_ops_W", logW, 3, 64'h123);
        chkOps("boot_ops_C", logC, 3, 64'h123);
        chk("boot_cursor", {xW, yW}, 0);
        chk("boot_idle_code", opCodeW, 0);
        clearLogs();

        // left at x=0: wrap goes to 5, clamp stays put
        press(0, 0, 1, 0, 0);
        idle(20);
        chkOps("left_wrap_ops", logW, 2, 64'h43);
        chk("left_wrap_x", xW, 5);
        chk("left_clamp_ops", 64'(logC.size()), 0);
        chk("left_clamp_x", xC, 0);
        clearLogs();

        // right+down together: only right acts
        press(0, 1, 0, 0, 1);
        idle(20);
        chkOps("rd_ops_W", logW, 2, 64'h43);
        chk("rd_W_xy", {xW, yW}, {3'd0, 3'd0});
        chkOps("rd_ops_C", logC, 2, 64'h43);
        chk("rd_C_xy", {xC, yC}, {3'd1, 3'd0});
        clearLogs();

        // up at y=0
        press(0, 0, 0, 1, 0);
        idle(20);
        chk("up_wrap_y", yW, 5);
        chk("up_clamp_ops", 64'(logC.size()), 0);
        clearLogs();

        // invalid move message
        validMove = 0;
        press(1, 0, 0, 0, 0);
        idle(40);
        chkOps("inv_ops", logW, 3, 64'h5bc);
        chk("inv_hold_span", (stampW.size() == 3) ? 64'(stampW[2] - stampW[1]) : 64'hdead, 8);
        chk("inv_player", playerW, 0);
        clearLogs();

        // valid move, opponent can play
        validMove = 1; hasTurn = 1;
        press(1, 0, 0, 0, 0);
        idle(50);
        chkOps("valid_ops", logW, 6, 64'h567893);
        chk("valid_player", {playerW, playerC}, 2'b11);
        clearLogs();

        // nobody can play: game over
        hasTurn = 0;
        press(1, 0, 0, 0, 0);
        idle(60);
        chkOps("end_ops", logW, 8, 64'h56789a4d);
        chk("end_game_over", {goW, goC}, 2'b11);
        clearLogs();

        // non-enter keys ignored in WIN_WAIT
        press(0, 1, 0, 0, 0);
        idle(10);
        chk("winwait_ignore", 64'(logW.size()), 0);

        press(1, 0, 0, 0, 0);
        idle(40);
        chkOps("clear_ops", logW, 4, 64'he123);
        chk("clear_state", {playerW, goW, xW, yW}, 0);
        clearLogs();

        // reset mid-FLIP after moving the cursor off origin
        press(0, 1, 0, 0, 0);
        idle(20);
        chk("pre_flip_x", xW, 1);
        hasTurn = 1;
        press(1, 0, 0, 0, 0);
        for (int i = 0; i < 100 && opCodeW != 4'd7; i++) @(negedge clk);
        chk("reach_flip", opCodeW, 7);
        #1 resetn = 0;
        #1;
        chk("async_rst_code", {opStartW, opCodeW, weW}, 0);
        chk("async_rst_state", {playerW, goW, xW, yW}, 0);
        chk("async_rst_C", {opCodeC, xC}, 0);
        idle(2);
        clearLogs();
        resetn = 1;
        idle(30);
        chkOps("reboot_ops", logW, 3, 64'h123);

        chk("we_monitor", 64'(weErr), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
